// File: rtl/smm_pkg.sv
// Shared types and 2x2 block pack/unpack helpers for the 4x4 block sequencer.
package smm_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_t;

  localparam int unsigned L00 = 0;
  localparam int unsigned L01 = 1;
  localparam int unsigned L10 = 2;
  localparam int unsigned L11 = 3;

  typedef struct packed {
    logic       valid;
    logic [1:0] dst;
    logic       first;
  } tag_t;

  localparam int unsigned TagW = $bits(tag_t);

  // Helpers work on vectors sized for the widest supported element; callers zero-extend/truncate.
  localparam int unsigned MaxDw = 64;

  function automatic int unsigned elem_idx(input logic bi, input logic bj, input int unsigned lane);
    int unsigned r, c;
    r = (bi ? 32'd2 : 32'd0) + (lane >> 1);
    c = (bj ? 32'd2 : 32'd0) + (lane & 32'd1);
    return 4 * r + c;
  endfunction

  function automatic logic [4*MaxDw-1:0] get_block(input logic [16*MaxDw-1:0] mat,
                                                   input int unsigned dw,
                                                   input logic bi, input logic bj);
    logic [16*MaxDw-1:0] lane_mask;
    logic [4*MaxDw-1:0]  blk;
    lane_mask = {(16*MaxDw){1'b1}} >> (16 * MaxDw - dw);
    blk       = '0;
    for (int unsigned l = L00; l <= L11; l++) begin
      blk |= (4*MaxDw)'((mat >> (elem_idx(bi, bj, l) * dw)) & lane_mask) << (l * dw);
    end
    return blk;
  endfunction

  function automatic logic [16*MaxDw-1:0] put_block(input logic [16*MaxDw-1:0] mat,
                                                    input logic [4*MaxDw-1:0] blk,
                                                    input int unsigned dw,
                                                    input logic bi, input logic bj);
    logic [16*MaxDw-1:0] lane_mask, lane, res;
    lane_mask = {(16*MaxDw){1'b1}} >> (16 * MaxDw - dw);
    res       = mat;
    for (int unsigned l = L00; l <= L11; l++) begin
      lane = ((16*MaxDw)'(blk) >> (l * dw)) & lane_mask;
      res  = (res & ~(lane_mask << (elem_idx(bi, bj, l) * dw)))
           | (lane << (elem_idx(bi, bj, l) * dw));
    end
    return res;
  endfunction

endpackage

// File: rtl/smm_tag_pipe.sv
// Fixed-depth shift register of result tags, aligned with the core's latency.
module smm_tag_pipe
  import smm_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [TagW-1:0] tag_i,
  output logic [TagW-1:0] tag_o
);

  logic [TagW-1:0] stage_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tag_o = stage_q[Depth-1];

endmodule

// File: rtl/smm_block_sequencer.sv
// Issues the 8 2x2 block products of a 4x4 multiply to the core and accumulates the results.
// Define SMM_SEQ_SATURATE_EN for saturating lane accumulation instead of wrap-around.
module smm_block_sequencer
  import smm_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned CORE_LAT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*DATAWIDTH-1:0] A_in,
  input  logic [16*DATAWIDTH-1:0] B_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [16*DATAWIDTH-1:0] C_res,
  output logic                    core_load,
  output logic                    core_sel,
  output logic [4*DATAWIDTH-1:0]  core_A,
  output logic [4*DATAWIDTH-1:0]  core_B,
  input  logic [4*DATAWIDTH-1:0]  core_C
);

  localparam int unsigned BlkW = 4 * DATAWIDTH;
  localparam int unsigned MatW = 16 * DATAWIDTH;

  state_t              state_q;
  logic [2:0]          p_q, p_nxt;
  logic [3:0]          retired_q;
  logic [MatW-1:0]     a_q, b_q, a_src, b_src;
  logic [BlkW-1:0]     acc_q [4];
  logic [BlkW-1:0]     acc_d [4];
  logic [BlkW-1:0]     issue_a, issue_b;
  logic [16*MaxDw-1:0] cres_ext;
  logic [MatW-1:0]     cres_d;
  tag_t                tag_push, tag_pop;
  logic [TagW-1:0]     tag_pop_raw;

  function automatic logic [BlkW-1:0] blk_of(input logic [MatW-1:0] m,
                                             input logic bi, input logic bj);
    return BlkW'(get_block((16*MaxDw)'(m), DATAWIDTH, bi, bj));
  endfunction

  function automatic logic [DATAWIDTH-1:0] lane_add(input logic [DATAWIDTH-1:0] x,
                                                    input logic [DATAWIDTH-1:0] y);
    logic [DATAWIDTH-1:0] s;
    s = x + y;
`ifdef SMM_SEQ_SATURATE_EN
    // Same-sign operands producing an opposite-sign sum overflowed.
    if ((x[DATAWIDTH-1] == y[DATAWIDTH-1]) && (s[DATAWIDTH-1] != x[DATAWIDTH-1])) begin
      s = x[DATAWIDTH-1] ? {1'b1, {(DATAWIDTH-1){1'b0}}} : {1'b0, {(DATAWIDTH-1){1'b1}}};
    end
`endif
    return s;
  endfunction

  // Block for the next issue slot; IDLE reads the live inputs so p=0 launches on acceptance.
  always_comb begin
    p_nxt   = (state_q == StIdle) ? 3'd0 : p_q + 3'd1;
    a_src   = (state_q == StIdle) ? A_in : a_q;
    b_src   = (state_q == StIdle) ? B_in : b_q;
    issue_a = blk_of(a_src, p_nxt[2], p_nxt[0]);
    issue_b = blk_of(b_src, p_nxt[0], p_nxt[1]);
  end

  always_comb begin
    tag_push.valid = core_load;
    tag_push.dst   = {p_q[2], p_q[1]};
    tag_push.first = ~p_q[0];
  end

  smm_tag_pipe #(
    .Depth(CORE_LAT)
  ) u_tag_pipe (
    .clk_i(clk),
    .rst_i(rst),
    .tag_i(tag_push),
    .tag_o(tag_pop_raw)
  );

  assign tag_pop = tag_t'(tag_pop_raw);

  always_comb begin
    for (int d = 0; d < 4; d++) acc_d[d] = acc_q[d];
    if (tag_pop.valid) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (tag_pop.first) begin
          acc_d[tag_pop.dst][l*DATAWIDTH +: DATAWIDTH] = core_C[l*DATAWIDTH +: DATAWIDTH];
        end else begin
          acc_d[tag_pop.dst][l*DATAWIDTH +: DATAWIDTH] =
              lane_add(acc_q[tag_pop.dst][l*DATAWIDTH +: DATAWIDTH],
                       core_C[l*DATAWIDTH +: DATAWIDTH]);
        end
      end
    end
  end

  always_comb begin
    cres_ext = '0;
    for (int unsigned d = 0; d < 4; d++) begin
      cres_ext = put_block(cres_ext, (4*MaxDw)'(acc_d[d]), DATAWIDTH, d[1], d[0]);
    end
    cres_d = MatW'(cres_ext);
  end

  assign core_sel = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      p_q       <= '0;
      retired_q <= '0;
      a_q       <= '0;
      b_q       <= '0;
      for (int d = 0; d < 4; d++) acc_q[d] <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      C_res     <= '0;
      core_load <= 1'b0;
      core_A    <= '0;
      core_B    <= '0;
    end else begin
      for (int d = 0; d < 4; d++) acc_q[d] <= acc_d[d];
      if (tag_pop.valid) retired_q <= retired_q + 4'd1;
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            a_q       <= A_in;
            b_q       <= B_in;
            p_q       <= 3'd0;
            retired_q <= '0;
            in_ready  <= 1'b0;
            core_load <= 1'b1;
            core_A    <= issue_a;
            core_B    <= issue_b;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          if (p_q == 3'd7) begin
            core_load <= 1'b0;
            core_A    <= '0;
            core_B    <= '0;
            state_q   <= StDrain;
          end else begin
            p_q    <= p_nxt;
            core_A <= issue_a;
            core_B <= issue_b;
          end
        end
        StDrain: begin
          if (tag_pop.valid && (retired_q == 4'd7)) begin
            out_valid <= 1'b1;
            C_res     <= cres_d;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_smm_block_sequencer.sv
// Self-checking bench: behavioural 2x2 core with fixed latency plus a plain 4x4 matrix model.
module tb_smm_block_sequencer;

  localparam int DW  = 32;
  localparam int LAT = 4;

  typedef logic [16*DW-1:0] mat_t;
  typedef logic [4*DW-1:0]  blk_t;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic core_load, core_sel;
  mat_t A_in, B_in, C_res;
  blk_t core_A, core_B, core_C;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  smm_block_sequencer #(
    .DATAWIDTH(DW),
    .CORE_LAT (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A_in     (A_in),
    .B_in     (B_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .C_res    (C_res),
    .core_load(core_load),
    .core_sel (core_sel),
    .core_A   (core_A),
    .core_B   (core_B),
    .core_C   (core_C)
  );

  function automatic logic [31:0] el(input mat_t m, input int r, input int c);
    return m[(4*r+c)*DW +: DW];
  endfunction

  function automatic blk_t prod2(input blk_t a, input blk_t b);
    logic [31:0] x [4];
    logic [31:0] y [4];
    for (int i = 0; i < 4; i++) begin
      x[i] = a[i*DW +: DW];
      y[i] = b[i*DW +: DW];
    end
    return {x[2]*y[1] + x[3]*y[3], x[2]*y[0] + x[3]*y[2],
            x[0]*y[1] + x[1]*y[3], x[0]*y[0] + x[1]*y[2]};
  endfunction

  // Core model: result appears for the edge LAT after the load edge; junk otherwise.
  blk_t cpipe [LAT];
  always @(posedge clk) begin
    cpipe[0] <= core_load ? prod2(core_A, core_B) : {$urandom, $urandom, $urandom, $urandom};
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign core_C = cpipe[LAT-1];

  // Reference: each C element is the sum of two half-products (k-block 0 then 1).
  function automatic mat_t ref_mul(input mat_t a, input mat_t b);
    mat_t        c;
    logic [31:0] h0, h1, s;
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        h0 = el(a, r, 0) * el(b, 0, col) + el(a, r, 1) * el(b, 1, col);
        h1 = el(a, r, 2) * el(b, 2, col) + el(a, r, 3) * el(b, 3, col);
        s  = h0 + h1;
`ifdef SMM_SEQ_SATURATE_EN
        if (h0[31] == h1[31] && s[31] != h0[31]) s = h0[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        c[(4*r+col)*DW +: DW] = s;
      end
    end
    return c;
  endfunction

  function automatic blk_t blk_ref(input mat_t m, input int br, input int bc);
    return {el(m, 2*br+1, 2*bc+1), el(m, 2*br+1, 2*bc), el(m, 2*br, 2*bc+1), el(m, 2*br, 2*bc)};
  endfunction

  function automatic mat_t rand_mat(input int mode);
    mat_t m;
    for (int i = 0; i < 16; i++) begin
      if (mode == 0) m[i*DW +: DW] = $urandom;
      else m[i*DW +: DW] = 32'($urandom_range(0, 200)) - 32'd100;
    end
    return m;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[(5*i)*DW +: DW] = 32'd1;
    return m;
  endfunction

  function automatic mat_t seq16();
    mat_t m;
    for (int i = 0; i < 16; i++) m[i*DW +: DW] = 32'(i + 1);
    return m;
  endfunction

  function automatic mat_t fill(input logic [31:0] v);
    mat_t m;
    for (int i = 0; i < 16; i++) m[i*DW +: DW] = v;
    return m;
  endfunction

  // Observations from the most recent job.
  int   obs_lat, obs_loads, obs_first, obs_last;
  blk_t obs_a [8];
  blk_t obs_b [8];
  mat_t obs_cres;
  logic obs_bp_ok, obs_sel_ok, obs_ready_after, obs_valid_after;

  task automatic do_job(input mat_t a, input mat_t b, input int bp);
    int w, t;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
    end
    in_valid  = 1'b1;
    A_in      = a;
    B_in      = b;
    out_ready = (bp == 0);
    @(negedge clk);
    obs_lat = -1; obs_loads = 0; obs_first = -1; obs_last = -1; obs_sel_ok = 1'b1; t = 0;
    while (obs_lat < 0 && t < 40) begin
      if (core_sel !== 1'b0) obs_sel_ok = 1'b0;
      if (core_load === 1'b1) begin
        if (obs_loads < 8) begin
          obs_a[obs_loads] = core_A;
          obs_b[obs_loads] = core_B;
        end
        obs_loads++;
        if (obs_first < 0) obs_first = t;
        obs_last = t;
      end
      if (out_valid === 1'b1) obs_lat = t;
      else begin
        in_valid = 1'($urandom_range(0, 1));
        A_in     = rand_mat(0);
        B_in     = rand_mat(0);
        @(negedge clk);
        t++;
      end
    end
    obs_cres  = C_res;
    obs_bp_ok = 1'b1;
    if (obs_lat >= 0) begin
      for (int i = 0; i < bp; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (C_res !== obs_cres || out_valid !== 1'b1 || in_ready !== 1'b0) obs_bp_ok = 1'b0;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    obs_valid_after = out_valid;
    obs_ready_after = in_ready;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A_in = '0; B_in = '0;
    repeat (2) @(negedge clk);
    checks += 7;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready: %b req 1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: %b req 0", out_valid); end
    if (C_res !== '0) begin failures++; $display("FAIL rst_c_res: %h req 0", C_res); end
    if (core_load !== 1'b0) begin failures++; $display("FAIL rst_core_load: %b req 0", core_load); end
    if (core_sel !== 1'b0) begin failures++; $display("FAIL rst_core_sel: %b req 0", core_sel); end
    if (core_A !== '0) begin failures++; $display("FAIL rst_core_A: %h req 0", core_A); end
    if (core_B !== '0) begin failures++; $display("FAIL rst_core_B: %h req 0", core_B); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_identity();
    mat_t b;
    b = seq16();
    do_job(ident(), b, 0);
    checks += 6;
    if (obs_cres !== b) begin failures++; $display("FAIL ident_c_res: %h req %h", obs_cres, b); end
    if (obs_lat !== 12) begin failures++; $display("FAIL ident_latency: %0d req 12", obs_lat); end
    if (obs_loads !== 8 || obs_first !== 0 || obs_last !== 7) begin
      failures++;
      $display("FAIL ident_load_run: count=%0d first=%0d last=%0d req 8/0/7",
               obs_loads, obs_first, obs_last);
    end
    if (obs_sel_ok !== 1'b1) begin failures++; $display("FAIL ident_core_sel: nonzero req 0"); end
    if (obs_valid_after !== 1'b0) begin
      failures++; $display("FAIL ident_out_valid_after: %b req 0", obs_valid_after);
    end
    if (obs_ready_after !== 1'b1) begin
      failures++; $display("FAIL ident_in_ready_after: %b req 1", obs_ready_after);
    end
  endtask

  task automatic test_uniform();
    do_job(fill(32'd2), fill(32'd3), 0);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (obs_cres[i*DW +: DW] !== 32'd24) begin
        failures++;
        $display("FAIL uniform_elem%0d: %0d req 24", i, obs_cres[i*DW +: DW]);
      end
    end
  endtask

  task automatic test_random_order();
    mat_t a, b, exp;
    for (int j = 0; j < 5; j++) begin
      a = rand_mat(j % 2);
      b = rand_mat((j + 1) % 2);
      exp = ref_mul(a, b);
      do_job(a, b, 0);
      checks++;
      if (obs_cres !== exp) begin
        failures++; $display("FAIL rand%0d_c_res: %h req %h", j, obs_cres, exp);
      end
      for (int p = 0; p < 8; p++) begin
        checks += 2;
        if (obs_a[p] !== blk_ref(a, p >> 2, p & 1)) begin
          failures++;
          $display("FAIL rand%0d_core_A_p%0d: %h req %h", j, p, obs_a[p],
                   blk_ref(a, p >> 2, p & 1));
        end
        if (obs_b[p] !== blk_ref(b, p & 1, (p >> 1) & 1)) begin
          failures++;
          $display("FAIL rand%0d_core_B_p%0d: %h req %h", j, p, obs_b[p],
                   blk_ref(b, p & 1, (p >> 1) & 1));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    mat_t a, b, exp;
    a = rand_mat(1);
    b = rand_mat(1);
    exp = ref_mul(a, b);
    do_job(a, b, 5);
    checks += 5;
    if (obs_lat !== 12) begin failures++; $display("FAIL bp_latency: %0d req 12", obs_lat); end
    if (obs_cres !== exp) begin failures++; $display("FAIL bp_c_res: %h req %h", obs_cres, exp); end
    if (obs_bp_ok !== 1'b1) begin failures++; $display("FAIL bp_hold: unstable req stable"); end
    if (obs_valid_after !== 1'b0) begin
      failures++; $display("FAIL bp_out_valid_after: %b req 0", obs_valid_after);
    end
    if (obs_ready_after !== 1'b1) begin
      failures++; $display("FAIL bp_in_ready_after: %b req 1", obs_ready_after);
    end
  endtask

  task automatic test_overflow();
    mat_t a, b, exp;
    a = '0;
    for (int c = 0; c < 4; c++) a[c*DW +: DW] = 32'h7FFF_FFFF;
    b = fill(32'd1);
    exp = ref_mul(a, b);
    do_job(a, b, 0);
    checks++;
    if (obs_cres !== exp) begin failures++; $display("FAIL ovf_c_res: %h req %h", obs_cres, exp); end
`ifndef SMM_SEQ_SATURATE_EN
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (el(obs_cres, 0, c) !== 32'hFFFF_FFFC) begin
        failures++; $display("FAIL ovf_row0_c%0d: %h req fffffffc", c, el(obs_cres, 0, c));
      end
    end
`endif
  endtask

  task automatic test_reset_mid_issue();
    mat_t b;
    int   w;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    A_in = rand_mat(0);
    B_in = rand_mat(0);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (core_load !== 1'b1) begin failures++; $display("FAIL mid_loading_p3: %b req 1", core_load); end
    rst = 1'b1;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid: %b req 0", out_valid); end
    if (core_load !== 1'b0) begin failures++; $display("FAIL mid_rst_core_load: %b req 0", core_load); end
    if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready: %b req 1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    b = seq16();
    do_job(ident(), b, 0);
    checks += 2;
    if (obs_cres !== b) begin failures++; $display("FAIL mid_next_c_res: %h req %h", obs_cres, b); end
    if (obs_lat !== 12) begin failures++; $display("FAIL mid_next_latency: %0d req 12", obs_lat); end
  endtask

  task automatic test_negative();
    mat_t b, exp;
    b = seq16();
    exp = ref_mul(fill(32'hFFFF_FFFF), b);
    do_job(fill(32'hFFFF_FFFF), b, 0);
    checks += 2;
    if (obs_cres !== exp) begin failures++; $display("FAIL neg_c_res: %h req %h", obs_cres, exp); end
    if (el(obs_cres, 2, 0) !== 32'hFFFF_FFE4) begin
      failures++; $display("FAIL neg_c20: %h req ffffffe4", el(obs_cres, 2, 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_identity();
    test_uniform();
    test_random_order();
    test_backpressure();
    test_overflow();
    test_reset_mid_issue();
    test_negative();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
